// File: rtl/ppg_pkg.sv
// ppg_pkg: definitions shared by the line-trigger sequencer and the
// ppg_v2r-side configuration logic.
//   ppg_seq_state_t : line sequencer FSM states (IDLE, RUN)
//   PPG_MIN_T_LINE  : default smallest accepted line period in clk_fast cycles
package ppg_pkg;

   typedef enum logic {
      PPG_SEQ_IDLE = 1'b0,
      PPG_SEQ_RUN  = 1'b1
   } ppg_seq_state_t;

   localparam int PPG_MIN_T_LINE = 4;

endpackage

// File: rtl/ppg_seq_cfg_chk.sv
// ppg_seq_cfg_chk: combinational check of a line-sequencer frame configuration.
// Ports:
//   v3mode    in  trig_h generation requested
//   t_line    in  line period in cycles (CW bits)
//   t_h_delay in  trig_l-to-trig_h offset in cycles (CW bits)
//   n_lines   in  lines per frame (LW bits)
//   cfg_ok    out configuration may be started
module ppg_seq_cfg_chk
   import ppg_pkg::*;
#(
   parameter int CW         = 16,
   parameter int LW         = 12,
   parameter int MIN_T_LINE = PPG_MIN_T_LINE
) (
   input  logic          v3mode,
   input  logic [CW-1:0] t_line,
   input  logic [CW-1:0] t_h_delay,
   input  logic [LW-1:0] n_lines,
   output logic          cfg_ok
);

   logic lines_ok;
   logic period_ok;
   logic delay_ok;

   assign lines_ok  = (n_lines != '0);
   assign period_ok = (t_line >= CW'(MIN_T_LINE));
   // trig_h must land strictly inside the line and never on the trig_l cycle;
   // t_h_delay < t_line is the same as t_h_delay <= t_line-1 without underflow.
   assign delay_ok  = !v3mode || ((t_h_delay != '0) && (t_h_delay < t_line));
   assign cfg_ok    = lines_ok && period_ok && delay_ok;

endmodule

// File: rtl/ppg_line_seq.sv
// ppg_line_seq: line-trigger sequencer feeding ppg_v2r. On an accepted start
// it emits n_lines trig_l pulses spaced t_line cycles apart and, in V3 mode,
// one trig_h per line t_h_delay cycles after trig_l. Frame geometry is
// latched at start.
// Ports:
//   clk_fast   in  fast PPG clock
//   rstn       in  asynchronous active-low reset
//   start      in  one-cycle frame start request
//   abort      in  one-cycle frame abort request
//   v3mode     in  enable trig_h (sampled at start)
//   t_line     in  line period in cycles (sampled at start)
//   t_h_delay  in  trig_l-to-trig_h offset (sampled at start)
//   n_lines    in  lines per frame (sampled at start)
//   trig_l     out line-start pulse
//   trig_h     out high-side trigger pulse (V3 only)
//   busy       out frame running
//   line_idx   out current line, 0-based
//   frame_done out pulse on normal frame completion
//   err_cfg    out sticky: last start request was rejected
module ppg_line_seq
   import ppg_pkg::*;
#(
   parameter int CW         = 16,
   parameter int LW         = 12,
   parameter int MIN_T_LINE = PPG_MIN_T_LINE
) (
   input  logic          clk_fast,
   input  logic          rstn,
   input  logic          start,
   input  logic          abort,
   input  logic          v3mode,
   input  logic [CW-1:0] t_line,
   input  logic [CW-1:0] t_h_delay,
   input  logic [LW-1:0] n_lines,
   output logic          trig_l,
   output logic          trig_h,
   output logic          busy,
   output logic [LW-1:0] line_idx,
   output logic          frame_done,
   output logic          err_cfg
);

   ppg_seq_state_t state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [LW-1:0]  line_n;
   logic           err_n;
   logic           done_n;
   logic           load;
   logic           cfg_ok;

   logic           v3_s;
   logic [CW-1:0]  t_line_s;
   logic [CW-1:0]  t_h_delay_s;
   logic [LW-1:0]  n_lines_s;

   logic           v3_n;
   logic [CW-1:0]  thd_n;
   logic           run_n;
   logic           trig_l_n;
   logic           trig_h_n;

   ppg_seq_cfg_chk #(
      .CW         (CW),
      .LW         (LW),
      .MIN_T_LINE (MIN_T_LINE)
   ) u_cfg_chk (
      .v3mode    (v3mode),
      .t_line    (t_line),
      .t_h_delay (t_h_delay),
      .n_lines   (n_lines),
      .cfg_ok    (cfg_ok)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      line_n  = line_idx;
      err_n   = err_cfg;
      done_n  = 1'b0;
      load    = 1'b0;

      case (state)
         PPG_SEQ_IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  load    = 1'b1;
                  err_n   = 1'b0;
                  state_n = PPG_SEQ_RUN;
                  cnt_n   = '0;
                  line_n  = '0;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         PPG_SEQ_RUN: begin
            // abort outranks everything, including a start in the same cycle
            if (abort) begin
               state_n = PPG_SEQ_IDLE;
               cnt_n   = '0;
               line_n  = '0;
            end else if (cnt == t_line_s - CW'(1)) begin
               cnt_n = '0;
               if (line_idx == n_lines_s - LW'(1)) begin
                  state_n = PPG_SEQ_IDLE;
                  line_n  = '0;
                  done_n  = 1'b1;
               end else begin
                  line_n = line_idx + LW'(1);
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            state_n = PPG_SEQ_IDLE;
         end
      endcase

      // Pulses are decoded from next-cycle values so every output is a flop;
      // on the start cycle the shadow registers are not loaded yet, so use
      // the inputs directly.
      v3_n     = load ? v3mode : v3_s;
      thd_n    = load ? t_h_delay : t_h_delay_s;
      run_n    = (state_n == PPG_SEQ_RUN);
      trig_l_n = run_n && (cnt_n == '0);
      trig_h_n = run_n && v3_n && (cnt_n == thd_n);
   end

   always_ff @(posedge clk_fast or negedge rstn) begin
      if (!rstn) begin
         state      <= PPG_SEQ_IDLE;
         cnt        <= '0;
         line_idx   <= '0;
         trig_l     <= 1'b0;
         trig_h     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         err_cfg    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         line_idx   <= line_n;
         trig_l     <= trig_l_n;
         trig_h     <= trig_h_n;
         busy       <= run_n;
         frame_done <= done_n;
         err_cfg    <= err_n;
      end
   end

   // Frame geometry shadows: only read while in RUN, so they need no reset.
   always_ff @(posedge clk_fast) begin
      if (load) begin
         v3_s        <= v3mode;
         t_line_s    <= t_line;
         t_h_delay_s <= t_h_delay;
         n_lines_s   <= n_lines;
      end
   end

endmodule

// File: tb/tb_ppg_line_seq.sv
// tb_ppg_line_seq: self-checking bench for ppg_line_seq. A frame-level
// reference model predicts every output from the accepted start cycle and the
// latched geometry using plain arithmetic (line = rel / T, phase = rel % T).
module tb_ppg_line_seq;

   localparam int CW    = 16;
   localparam int LW    = 12;
   localparam int MIN_T = 4;
   localparam int VW    = LW + 5;

   logic          clk_fast = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          v3mode = 1'b0;
   logic [CW-1:0] t_line = '0;
   logic [CW-1:0] t_h_delay = '0;
   logic [LW-1:0] n_lines = '0;
   logic          trig_l, trig_h, busy, frame_done, err_cfg;
   logic [LW-1:0] line_idx;

   int errors = 0;
   int checks = 0;

   longint edge_no = 0;
   bit     m_active = 1'b0;
   bit     m_err = 1'b0;
   longint m_es = 0;
   longint m_T = 0, m_D = 0, m_N = 0;
   bit     m_v3 = 1'b0;

   // {trig_l, trig_h, busy, frame_done, err_cfg, line_idx}
   logic [VW-1:0] exp_vec, got_vec;

   ppg_line_seq #(.CW(CW), .LW(LW), .MIN_T_LINE(MIN_T)) dut (
      .clk_fast   (clk_fast),
      .rstn       (rstn),
      .start      (start),
      .abort      (abort),
      .v3mode     (v3mode),
      .t_line     (t_line),
      .t_h_delay  (t_h_delay),
      .n_lines    (n_lines),
      .trig_l     (trig_l),
      .trig_h     (trig_h),
      .busy       (busy),
      .line_idx   (line_idx),
      .frame_done (frame_done),
      .err_cfg    (err_cfg)
   );

   always #5 clk_fast = ~clk_fast;

   function automatic bit cfg_valid(bit v3, longint T, longint D, longint N);
      return (N != 0) && (T >= MIN_T) && (!v3 || (D >= 1 && D <= T - 1));
   endfunction

   function automatic logic [VW-1:0] model_out(longint e);
      longint rel, total, ph, ln;
      logic [VW-1:0] v;
      v = '0;
      v[LW] = m_err;
      if (m_active) begin
         rel   = e - m_es;
         total = m_N * m_T;
         if (rel < total) begin
            ph = rel % m_T;
            ln = rel / m_T;
            v[LW+4] = (ph == 0);
            v[LW+3] = m_v3 && (ph == m_D);
            v[LW+2] = 1'b1;
            v[LW-1:0] = LW'(ln);
         end else if (rel == total) begin
            v[LW+1] = 1'b1;
         end
      end
      return v;
   endfunction

   // One clock: update the model from the inputs sampled at this edge, then
   // capture DUT outputs 1 ns later and drop the single-cycle requests.
   task automatic step();
      bit in_run;
      @(posedge clk_fast);
      edge_no++;
      in_run = m_active && ((edge_no - 1 - m_es) < m_N * m_T);
      if (in_run) begin
         if (abort) m_active = 1'b0;
      end else if (start) begin
         if (cfg_valid(v3mode, t_line, t_h_delay, n_lines)) begin
            m_active = 1'b1;
            m_es     = edge_no;
            m_T      = t_line;
            m_D      = t_h_delay;
            m_N      = n_lines;
            m_v3     = v3mode;
            m_err    = 1'b0;
         end else begin
            m_err = 1'b1;
         end
      end
      exp_vec = model_out(edge_no);
      #1;
      got_vec = {trig_l, trig_h, busy, frame_done, err_cfg, line_idx};
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic set_cfg(bit v3, int T, int D, int N);
      v3mode    = v3;
      t_line    = CW'(T);
      t_h_delay = CW'(D);
      n_lines   = LW'(N);
   endtask

   task automatic test_reset();
      #2;
      got_vec = {trig_l, trig_h, busy, frame_done, err_cfg, line_idx};
      checks++;
      if (got_vec !== '0) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", got_vec, {VW{1'b0}});
      end
      @(negedge clk_fast);
      rstn = 1'b1;
   endtask

   task automatic test_nonv3();
      int nl = 0, nh = 0, nd = 0;
      set_cfg(1'b0, 100, 0, 3);
      start = 1'b1;
      for (int i = 0; i < 310; i++) begin
         step();
         if (i == 10) t_line = CW'(77);
         nl += int'(got_vec[LW+4]);
         nh += int'(got_vec[LW+3]);
         nd += int'(got_vec[LW+1]);
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL nonv3 i=%0d got=%h exp=%h", i, got_vec, exp_vec);
         end
      end
      checks++;
      if (nl != 3 || nh != 0 || nd != 1) begin
         errors++;
         $display("FAIL nonv3_counts trig_l=%0d trig_h=%0d done=%0d exp 3/0/1", nl, nh, nd);
      end
   endtask

   task automatic test_v3();
      int nl = 0, nh = 0, done_at = -1;
      set_cfg(1'b1, 8064, 3380, 2);
      start = 1'b1;
      for (int i = 0; i < 16140; i++) begin
         step();
         nl += int'(got_vec[LW+4]);
         nh += int'(got_vec[LW+3]);
         if (got_vec[LW+1]) done_at = i;
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL v3 i=%0d got=%h exp=%h", i, got_vec, exp_vec);
         end
      end
      // step index i corresponds to cycle k+1+i, so k+16129 is i=16128
      checks++;
      if (nl != 2 || nh != 2 || done_at != 16128) begin
         errors++;
         $display("FAIL v3_counts trig_l=%0d trig_h=%0d done_at=%0d exp 2/2/16128", nl, nh, done_at);
      end
   endtask

   task automatic test_invalid();
      for (int c = 0; c < 3; c++) begin
         case (c)
            0: set_cfg(1'b0, 100, 0, 0);
            1: set_cfg(1'b0, 3, 0, 1);
            default: set_cfg(1'b1, 100, 100, 1);
         endcase
         start = 1'b1;
         for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (got_vec !== exp_vec) begin
               errors++;
               $display("FAIL invalid cfg=%0d i=%0d got=%h exp=%h", c, i, got_vec, exp_vec);
            end
         end
         checks++;
         if (err_cfg !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL invalid_flag cfg=%0d err_cfg=%b busy=%b exp 1/0", c, err_cfg, busy);
         end
      end
      set_cfg(1'b1, 10, 9, 1);
      start = 1'b1;
      for (int i = 0; i < 14; i++) begin
         step();
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL recover i=%0d got=%h exp=%h", i, got_vec, exp_vec);
         end
      end
      checks++;
      if (err_cfg !== 1'b0) begin
         errors++;
         $display("FAIL err_clear err_cfg=%b exp 0", err_cfg);
      end
   endtask

   task automatic test_abort();
      set_cfg(1'b0, 100, 0, 5);
      start = 1'b1;
      for (int i = 0; i < 600; i++) begin
         step();
         if (i == 148) abort = 1'b1;
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL abort i=%0d got=%h exp=%h", i, got_vec, exp_vec);
         end
      end
      // abort and start together while running: abort wins, no restart
      set_cfg(1'b1, 20, 5, 4);
      start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (i == 25) begin
            abort = 1'b1;
            start = 1'b1;
         end
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL abort_start i=%0d got=%h exp=%h", i, got_vec, exp_vec);
         end
      end
      abort = 1'b1;
      step();
      checks++;
      if (got_vec !== exp_vec) begin
         errors++;
         $display("FAIL abort_idle got=%h exp=%h", got_vec, exp_vec);
      end
   endtask

   task automatic test_busy_start();
      set_cfg(1'b0, 100, 0, 2);
      start = 1'b1;
      for (int i = 0; i < 215; i++) begin
         step();
         if (i == 8) t_line = CW'(50);
         if (i == 40) start = 1'b1;
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL busy_start i=%0d got=%h exp=%h", i, got_vec, exp_vec);
         end
      end
   endtask

   task automatic test_reset_b2b();
      bit seen;
      set_cfg(1'b1, 100, 40, 3);
      start = 1'b1;
      for (int i = 0; i < 119; i++) begin
         step();
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL pre_reset i=%0d got=%h exp=%h", i, got_vec, exp_vec);
         end
      end
      #2;
      rstn = 1'b0;
      m_active = 1'b0;
      m_err = 1'b0;
      #1;
      got_vec = {trig_l, trig_h, busy, frame_done, err_cfg, line_idx};
      checks++;
      if (got_vec !== '0) begin
         errors++;
         $display("FAIL midframe_reset got=%h exp=%h", got_vec, {VW{1'b0}});
      end
      @(negedge clk_fast);
      rstn = 1'b1;
      set_cfg(1'b0, 10, 0, 2);
      start = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL b2b_first i=%0d got=%h exp=%h", i, got_vec, exp_vec);
         end
         seen = got_vec[LW+1];
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL b2b_done_timeout frame_done=0 exp 1 within 40 cycles");
      end
      set_cfg(1'b0, 7, 0, 1);
      start = 1'b1;
      step();
      checks++;
      if (trig_l !== 1'b1 || busy !== 1'b1 || got_vec !== exp_vec) begin
         errors++;
         $display("FAIL b2b_restart got=%h exp=%h", got_vec, exp_vec);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) begin
            int T;
            T = int'($urandom_range(12, 3));
            set_cfg(1'b1 & $urandom_range(1), T, int'($urandom_range(T)), int'($urandom_range(4)));
            start = 1'b1;
         end else if ($urandom_range(39) == 0) begin
            abort = 1'b1;
         end
         step();
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL random i=%0d got=%h exp=%h", i, got_vec, exp_vec);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nonv3();
      test_v3();
      test_invalid();
      test_abort();
      test_busy_start();
      test_reset_b2b();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
